// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module : adder_pkg
// Purpose: Shared definitions for the pipelined add/subtract datapath.
//          Pipeline-depth helper and operating-mode encodings.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // One pipeline stage per CHUNK-bit slice of the operands.
  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module : pipelined_adder_if
// Purpose: Operand/result handshake bundle for pipelined_adder.
// Ports  : in_valid/in_ready/a/b/cin/sub   - operand side
//          out_valid/out_ready/s/cout/ovf  - result side
//          master : producer/consumer view (testbench or upstream logic)
//          slave  : adder view
// Rev    : 1.0  initial release
// ============================================================================
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/adder_stage.sv
`default_nettype none
// ============================================================================
// Module : adder_stage
// Purpose: One pipeline stage of the pipelined adder. Adds slice IDX of the
//          operands with a CHUNK-bit ripple of full adders (each built from
//          two half adders and an OR) and registers the partial result.
// Ports  : clk, rst          - clock, synchronous active-high reset
//          load_i            - capture upstream data this cycle
//          adv_i             - this stage's content leaves this cycle
//          a_i/bp_i/sum_i    - operand A, conditioned operand B, partial sum
//          carry_i           - carry into this slice
//          valid_o           - stage holds a live operation
//          a_o/bp_o/sum_o    - registered operands and partial sum
//          carry_o           - registered carry out of this slice
//          cmsb_o            - registered carry into the slice's top bit
// Rev    : 1.0  initial release
// ============================================================================
module adder_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] bp_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] bp_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             cmsb_o
);

  localparam int unsigned LSB = IDX * CHUNK;

  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_ha1_s;
  logic [CHUNK-1:0] w_ha1_c;
  logic [CHUNK-1:0] w_ha2_c;
  logic [WIDTH-1:0] sum_d;

  logic             valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bp_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cmsb_q;

  always_comb begin
    w_c[0]  = carry_i;
    w_ha1_s = '0;
    w_ha1_c = '0;
    w_ha2_c = '0;
    sum_d   = sum_i;
    for (int i = 0; i < int'(CHUNK); i++) begin
      w_ha1_s[i]     = a_i[LSB+i] ^ bp_i[LSB+i];
      w_ha1_c[i]     = a_i[LSB+i] & bp_i[LSB+i];
      sum_d[LSB+i]   = w_ha1_s[i] ^ w_c[i];
      w_ha2_c[i]     = w_ha1_s[i] & w_c[i];
      w_c[i+1]       = w_ha1_c[i] | w_ha2_c[i];
    end
  end

  // Load has priority over drain: a stage that empties and refills in the
  // same cycle simply stays valid with the new operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      bp_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      a_q     <= a_i;
      bp_q    <= bp_i;
      sum_q   <= sum_d;
      carry_q <= w_c[CHUNK];
      cmsb_q  <= w_c[CHUNK-1];
    end else if (adv_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign bp_o    = bp_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign cmsb_o  = cmsb_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module : pipelined_adder
// Purpose: Parametrised pipelined add/subtract unit. WIDTH-bit operands are
//          processed CHUNK bits per stage with the carry registered between
//          stages; valid/ready handshake with backpressure on both sides.
// Ports  : clk, rst - clock, synchronous active-high reset
//          bus      - pipelined_adder_if.slave (operands in, result out)
// Rev    : 1.0  initial release
// ============================================================================
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic               clk,
  input logic               rst,
  pipelined_adder_if.slave  bus
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
  end

  logic [STAGES-1:0]            w_valid;
  logic [STAGES-1:0]            w_adv;
  logic [STAGES-1:0]            w_load;
  logic [STAGES:0][WIDTH-1:0]   w_a;
  logic [STAGES:0][WIDTH-1:0]   w_bp;
  logic [STAGES:0][WIDTH-1:0]   w_sum;
  logic [STAGES:0]              w_carry;
  logic [STAGES-1:0]            w_cmsb;
  logic                         w_in_ready;

  // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
  assign w_a[0]     = bus.a;
  assign w_bp[0]    = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
  assign w_sum[0]   = '0;
  assign w_carry[0] = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;

  // Ready looks only at pipeline state (never at in_valid); rst gates it so
  // nothing is accepted while the pipe is being cleared.
  assign w_in_ready = !rst && (!w_valid[0] || w_adv[0]);
  assign w_load[0]  = bus.in_valid && w_in_ready;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    if (k == int'(STAGES) - 1) begin : g_last
      assign w_adv[k] = w_valid[k] && bus.out_ready;
    end else begin : g_mid
      // An empty successor lets this stage move even if the output stalls.
      assign w_adv[k] = w_valid[k] && (!w_valid[k+1] || w_adv[k+1]);
    end

    if (k > 0) begin : g_load
      assign w_load[k] = w_adv[k-1];
    end

    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load_i  (w_load[k]),
      .adv_i   (w_adv[k]),
      .a_i     (w_a[k]),
      .bp_i    (w_bp[k]),
      .sum_i   (w_sum[k]),
      .carry_i (w_carry[k]),
      .valid_o (w_valid[k]),
      .a_o     (w_a[k+1]),
      .bp_o    (w_bp[k+1]),
      .sum_o   (w_sum[k+1]),
      .carry_o (w_carry[k+1]),
      .cmsb_o  (w_cmsb[k])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid[STAGES-1];
  assign bus.s         = w_sum[STAGES];
  assign bus.cout      = w_carry[STAGES];
  assign bus.ovf       = w_cmsb[STAGES-1] ^ w_carry[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_pipelined_adder
// Purpose: Self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4).
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(16)) bus ();

  pipelined_adder #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    bit          lit;
    logic [15:0] ls;
    logic        lc;
    logic        lo;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Directed-vector expectations, attached to the next accepted operation.
  bit          pend_lit = 1'b0;
  logic [15:0] pend_s;
  logic        pend_c;
  logic        pend_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on the operand values.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    int          sa, sb, res;
    logic [16:0] u;
    logic [15:0] sv;
    logic        c;
    logic        o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      sv  = a - b;
      c   = (a >= b);
      res = sa - sb;
    end else begin
      u   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      sv  = u[15:0];
      c   = u[16];
      res = sa + sb + int'(cin);
    end
    o = (res > 32767) || (res < -32768);
    return {sv, c, o};
  endfunction

  // Compare process: all sampling on the falling edge.
  bit          stall = 1'b0;
  logic [15:0] hold_s;
  logic        hold_c;
  logic        hold_o;

  always @(negedge clk) begin
    exp_t        e;
    logic [17:0] m;
    if (rst) begin
      q.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("hold_s", {16'b0, bus.s}, {16'b0, hold_s});
        chk("hold_flags", {30'b0, bus.cout, bus.ovf}, {30'b0, hold_c, hold_o});
      end
      if (bus.out_valid) begin
        chk("result_expected", {31'b0, q.size() != 0}, 32'd1);
        if (bus.out_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("s", {16'b0, bus.s}, {16'b0, e.s});
          chk("cout", {31'b0, bus.cout}, {31'b0, e.c});
          chk("ovf", {31'b0, bus.ovf}, {31'b0, e.o});
          if (e.lit) begin
            chk("lit_s", {16'b0, bus.s}, {16'b0, e.ls});
            chk("lit_flags", {30'b0, bus.cout, bus.ovf}, {30'b0, e.lc, e.lo});
          end
        end
      end
      stall  = bus.out_valid && !bus.out_ready;
      hold_s = bus.s;
      hold_c = bus.cout;
      hold_o = bus.ovf;
      if (bus.in_valid && bus.in_ready) begin
        m     = model(bus.a, bus.b, bus.cin, bus.sub);
        e.s   = m[17:2];
        e.c   = m[1];
        e.o   = m[0];
        e.lit = pend_lit;
        e.ls  = pend_s;
        e.lc  = pend_c;
        e.lo  = pend_o;
        q.push_back(e);
      end
    end
  end

  // Present one operation and hold it until accepted; in_valid stays high.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input bit lit, input logic [15:0] ls,
                      input logic lc, input logic lo);
    int t;
    bus.a      = a;
    bus.b      = b;
    bus.cin    = cin;
    bus.sub    = sub;
    bus.in_valid = 1'b1;
    pend_lit   = lit;
    pend_s     = ls;
    pend_c     = lc;
    pend_o     = lo;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    pend_lit = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    idle();
    while (q.size() != 0 && t < 200) begin
      t++;
      @(posedge clk);
    end
    if (t >= 200) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h4321;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset with operands offered: nothing accepted, outputs cleared.
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("rst_s", {16'b0, bus.s}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Cross-chunk carry with exact latency.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    idle();
    repeat (3) begin
      @(negedge clk);
      chk("latency_early", {31'b0, bus.out_valid}, 32'd0);
    end
    @(negedge clk);
    chk("latency_4", {31'b0, bus.out_valid}, 32'd1);
    drain();

    // Flags and subtract, back to back.
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain();

    // Backpressure: 8 random ops, output stalled 6 cycles then toggling.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
               1'b0, 16'h0, 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("full_out_valid", {31'b0, bus.out_valid}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 30; i++) begin
          bus.out_ready = ~bus.out_ready;
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    send(16'h3333, 16'h0444, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    send(16'h5555, 16'h0666, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("flush_quiet", {31'b0, bus.out_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
